axi_ddr_responder: RTL and testbench
====================================

AXI_DDR_RESPONDER -- requirements
Module: axi_ddr_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, meaning AXI data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning AXI byte-address width.
REQ-003 SHALL have parameter DEPTH, default 1024, meaning memory depth in DATA_WIDTH words (power of 2).
REQ-004 SHALL have parameter RD_LATENCY, default 4, meaning extra read wait cycles (macro-enabled only).
REQ-005 SHALL have port clk, input, 1, meaning the single clock.
REQ-006 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have AW ports S_AXI_AWADDR in ADDR_WIDTH, S_AXI_AWLEN in 8, S_AXI_AWVALID in 1 and S_AXI_AWREADY out 1.
REQ-008 SHALL have W ports S_AXI_WDATA in DATA_WIDTH, S_AXI_WSTRB in DATA_WIDTH/8, S_AXI_WLAST in 1, S_AXI_WVALID in 1 and S_AXI_WREADY out 1.
REQ-009 SHALL have B ports S_AXI_BRESP out 2, S_AXI_BVALID out 1 and S_AXI_BREADY in 1.
REQ-010 SHALL have AR ports S_AXI_ARADDR in ADDR_WIDTH, S_AXI_ARLEN in 8, S_AXI_ARVALID in 1 and S_AXI_ARREADY out 1.
REQ-011 SHALL have R ports S_AXI_RDATA out DATA_WIDTH, S_AXI_RRESP out 2 (always 2'b00), S_AXI_RLAST out 1, S_AXI_RVALID out 1 and S_AXI_RREADY in 1.

Function
REQ-012 SHALL be the DDR-side responder for the team's AXI4 burst master: full-width INCR bursts only, no IDs, one outstanding write and one outstanding read.
REQ-013 SHALL form the word index as addr >> log2(DATA_WIDTH/8), incrementing by 1 per beat modulo DEPTH; unaligned low bits are ignored.
REQ-014 SHALL run a write FSM W_IDLE -> W_DATA on AW handshake -> W_RESP after beat AWLEN+1 -> W_IDLE on B handshake.
REQ-015 SHALL drive AWREADY=1 only in W_IDLE, WREADY=1 only in W_DATA and BVALID=1 only in W_RESP.
REQ-016 SHALL write each accepted W beat with byte-lane granularity per WSTRB in the handshake cycle.
REQ-017 SHALL end the burst on beat count AWLEN+1 regardless of WLAST; BRESP=2'b10 if WLAST was early or absent on the final beat, otherwise 2'b00.
REQ-018 SHALL run a read FSM R_IDLE -> R_WAIT on AR handshake -> R_DATA -> R_IDLE after the RLAST handshake; ARREADY=1 only in R_IDLE.
REQ-019 SHALL hold RDATA/RLAST stable while RVALID=1 and RREADY=0, assert RLAST on beat ARLEN+1, and deliver one beat per cycle while RREADY=1.
REQ-020 SHALL keep read and write channels fully independent; a read of a word written in the same cycle returns the old data.

Reset
REQ-021 SHALL, while rst=1 at a clk edge, set both FSMs idle and force AWREADY, WREADY, BVALID, ARREADY, RVALID and RLAST to 0 and BRESP, RDATA to 0; AWREADY/ARREADY SHALL rise the cycle after rst falls.
REQ-022 SHALL abort any in-flight burst on reset without issuing B or R beats; memory contents SHALL be retained.

Configuration
REQ-023 SHALL, with AXI_DDR_RESP_LATENCY_EN defined, hold R_WAIT RD_LATENCY cycles, giving first RVALID RD_LATENCY+2 cycles after the AR handshake.
REQ-024 SHALL, without AXI_DDR_RESP_LATENCY_EN, give first RVALID 2 cycles after the AR handshake, with RD_LATENCY ignored.

Verification
REQ-025 SHALL cover a write burst to addr 0x100 with AWLEN=7, data i and WSTRB all ones, then a read of the same burst -> 8 beats of data 0..7, RLAST on beat 8, BRESP=0.
REQ-026 SHALL cover writing 0xFF.. to word 0 and then WSTRB=16'h0001 with data 0 -> readback 0xFF..FF00.
REQ-027 SHALL cover WLAST on beat 3 of AWLEN=7 -> 8 beats accepted and BRESP=2'b10.
REQ-028 SHALL cover a read with RREADY toggling 1/0 -> RDATA held during stalls and 8 beats in order without loss.
REQ-029 SHALL cover an AR at the last word (DEPTH-1) with ARLEN=1 -> beats from words DEPTH-1 then 0.
REQ-030 SHALL cover rst pulsed mid-write at beat 4 -> no BVALID, AWREADY=1 the cycle after release, and beats 0..3 retained.

Source files
------------

// File: rtl/axi_ddr_responder.sv
// axi_ddr_responder: AXI4 INCR burst memory slave, one write and one read outstanding; define AXI_DDR_RESP_LATENCY_EN for RD_LATENCY extra read wait cycles.
module axi_ddr_responder #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int RD_LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]              S_AXI_AWLEN,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WLAST,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]              S_AXI_ARLEN,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RLAST,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int SH = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
`ifdef AXI_DDR_RESP_LATENCY_EN
  localparam logic [31:0] WAIT = 32'(RD_LATENCY + 1);
`else
  localparam logic [31:0] WAIT = 32'(1 + 0 * RD_LATENCY);
`endif
  localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic live;
  logic [1:0] w_state, r_state;
  logic [IW-1:0] w_idx, r_idx;
  logic [7:0] w_len, w_cnt, r_len, r_cnt;
  logic w_err, w_beat, w_last;
  logic [31:0] r_wait;
  // live keeps both READYs low for the first cycle after reset releases
  assign S_AXI_AWREADY = live && w_state == W_IDLE;
  assign S_AXI_WREADY = w_state == W_DATA;
  assign S_AXI_BVALID = w_state == W_RESP;
  assign S_AXI_BRESP = S_AXI_BVALID && w_err ? 2'b10 : 2'b00;
  assign S_AXI_ARREADY = live && r_state == R_IDLE;
  assign S_AXI_RVALID = r_state == R_DATA;
  assign S_AXI_RLAST = S_AXI_RVALID && r_cnt == r_len;
  assign S_AXI_RRESP = 2'b00;
  assign w_beat = S_AXI_WREADY && S_AXI_WVALID;
  assign w_last = w_cnt == w_len;
  always_ff @(posedge clk) live <= !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_idx <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_err <= 1'b0;
    end else if (S_AXI_AWREADY && S_AXI_AWVALID) begin
      w_state <= W_DATA;
      w_idx <= IW'(S_AXI_AWADDR >> SH);
      w_len <= S_AXI_AWLEN;
      w_cnt <= '0;
      w_err <= 1'b0;
    end else if (w_beat) begin
      w_idx <= w_idx + 1'b1;
      w_cnt <= w_cnt + 8'd1;
      w_err <= w_err | (S_AXI_WLAST != w_last);
      if (w_last) w_state <= W_RESP;
    end else if (S_AXI_BVALID && S_AXI_BREADY) begin
      w_state <= W_IDLE;
    end
  end
  // memory is never reset so contents survive an aborted burst
  always_ff @(posedge clk) begin
    if (!rst && w_beat)
      for (int b = 0; b < NB; b++)
        if (S_AXI_WSTRB[b]) mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_idx <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_wait <= '0;
      S_AXI_RDATA <= '0;
    end else if (S_AXI_ARREADY && S_AXI_ARVALID) begin
      r_state <= R_WAIT;
      r_idx <= IW'(S_AXI_ARADDR >> SH);
      r_len <= S_AXI_ARLEN;
      r_cnt <= '0;
      r_wait <= WAIT;
    end else if (r_state == R_WAIT) begin
      if (r_wait == '0) begin
        r_state <= R_DATA;
        S_AXI_RDATA <= mem[r_idx];
        r_idx <= r_idx + 1'b1;
      end else begin
        r_wait <= r_wait - 32'd1;
      end
    end else if (S_AXI_RVALID && S_AXI_RREADY) begin
      if (S_AXI_RLAST) begin
        r_state <= R_IDLE;
      end else begin
        S_AXI_RDATA <= mem[r_idx];
        r_idx <= r_idx + 1'b1;
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_axi_ddr_responder.sv
// tb_axi_ddr_responder: randomized bursts checked against an array memory model and per-beat queues.
module tb_axi_ddr_responder;
  localparam int DEPTH = 1024;
`ifdef AXI_DDR_RESP_LATENCY_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif
  logic clk = 0, rst = 1;
  logic [31:0] S_AXI_AWADDR = 0, S_AXI_ARADDR = 0;
  logic [7:0] S_AXI_AWLEN = 0, S_AXI_ARLEN = 0;
  logic S_AXI_AWVALID = 0, S_AXI_AWREADY, S_AXI_WLAST = 0, S_AXI_WVALID = 0, S_AXI_WREADY;
  logic [127:0] S_AXI_WDATA = 0, S_AXI_RDATA;
  logic [15:0] S_AXI_WSTRB = 0;
  logic [1:0] S_AXI_BRESP, S_AXI_RRESP;
  logic S_AXI_BVALID, S_AXI_BREADY = 0, S_AXI_ARVALID = 0, S_AXI_ARREADY;
  logic S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY = 0;
  axi_ddr_responder dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  logic [127:0] mdl [DEPTH];
  logic [127:0] wbuf [256];
  logic [15:0] sbuf [256];
  logic [127:0] exp_r [$];
  bit exp_l [$];
  logic [1:0] exp_b [$];
  logic [127:0] rd_beats [256];
  int rd_cnt = 0, r_done = 0, b_done = 0, w_hs = 0;
  logic [1:0] b_last = 0;
  bit hold = 0;
  logic [127:0] hd;
  logic hl;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [127:0] er;
    bit el;
    if (rst) hold = 0;
    else begin
      if (hold) begin
        chk("r_hold_data", S_AXI_RDATA, hd);
        chk("r_hold_last", S_AXI_RLAST, hl);
      end
      chk("aw_ready_exclusive", S_AXI_AWREADY && (S_AXI_WREADY || S_AXI_BVALID), 0);
      chk("ar_ready_exclusive", S_AXI_ARREADY && S_AXI_RVALID, 0);
      chk("rresp", S_AXI_RRESP, 0);
      if (S_AXI_WVALID && S_AXI_WREADY) w_hs++;
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          er = exp_r.pop_front();
          el = exp_l.pop_front();
          chk("r_data", S_AXI_RDATA, er);
          chk("r_last", S_AXI_RLAST, el);
        end
        if (rd_cnt < 256) rd_beats[rd_cnt] = S_AXI_RDATA;
        rd_cnt++;
        if (S_AXI_RLAST) r_done++;
      end
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
        else chk("b_resp", S_AXI_BRESP, exp_b.pop_front());
        b_last = S_AXI_BRESP;
        b_done++;
      end
      hold = S_AXI_RVALID && !S_AXI_RREADY;
      hd = S_AXI_RDATA;
      hl = S_AXI_RLAST;
    end
  end
  task automatic pulse_reset();
    rst = 1;
    @(posedge clk); #1;
    chk("rst_awready", S_AXI_AWREADY, 0);
    chk("rst_wready", S_AXI_WREADY, 0);
    chk("rst_bvalid", S_AXI_BVALID, 0);
    chk("rst_arready", S_AXI_ARREADY, 0);
    chk("rst_rvalid", S_AXI_RVALID, 0);
    chk("rst_rlast", S_AXI_RLAST, 0);
    chk("rst_bresp", S_AXI_BRESP, 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    rst = 0;
    #1 chk("rst_awready_before_edge", S_AXI_AWREADY, 0);
    @(posedge clk); #1;
    chk("rst_awready_after", S_AXI_AWREADY, 1);
    chk("rst_arready_after", S_AXI_ARREADY, 1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_no_bvalid", S_AXI_BVALID, 0);
    end
  endtask
  task automatic wr(input logic [31:0] addr, input int len, input int lastpos, input int abort_at);
    int idx, k, w0, b0;
    idx = int'((addr >> 4) % DEPTH);
    S_AXI_AWADDR = addr;
    S_AXI_AWLEN = 8'(len);
    S_AXI_AWVALID = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (!S_AXI_AWREADY && k < 100);
    if (!S_AXI_AWREADY) chk("aw_timeout", 0, 1);
    @(posedge clk); #1;
    S_AXI_AWVALID = 0;
    if (abort_at < 0) exp_b.push_back(lastpos == len ? 2'b00 : 2'b10);
    w0 = w_hs;
    for (int i = 0; i <= len; i++) begin
      if (i == abort_at) begin
        pulse_reset();
        chk("w_beats_abort", w_hs - w0, abort_at);
        return;
      end
      while ($urandom_range(3) == 0) begin @(posedge clk); #1; end
      S_AXI_WDATA = wbuf[i];
      S_AXI_WSTRB = sbuf[i];
      S_AXI_WLAST = (i == lastpos);
      S_AXI_WVALID = 1;
      k = 0;
      do begin @(negedge clk); k++; end while (!S_AXI_WREADY && k < 100);
      if (!S_AXI_WREADY) chk("w_timeout", 0, 1);
      @(posedge clk); #1;
      for (int b = 0; b < 16; b++)
        if (sbuf[i][b]) mdl[idx][8*b +: 8] = wbuf[i][8*b +: 8];
      idx = (idx + 1) % DEPTH;
      S_AXI_WVALID = 0;
      S_AXI_WLAST = 0;
    end
    chk("w_beats", w_hs - w0, len + 1);
    b0 = b_done;
    repeat ($urandom_range(2)) @(posedge clk);
    #1 S_AXI_BREADY = 1;
    k = 0;
    while (b_done == b0 && k < 100) begin @(posedge clk); #1; k++; end
    chk("b_timeout", b_done != b0, 1);
    S_AXI_BREADY = 0;
  endtask
  task automatic rd(input logic [31:0] addr, input int len, input int mode);
    int idx, k, c, lat, d0;
    idx = int'((addr >> 4) % DEPTH);
    for (int i = 0; i <= len; i++) begin
      exp_r.push_back(mdl[(idx + i) % DEPTH]);
      exp_l.push_back(i == len);
    end
    rd_cnt = 0;
    d0 = r_done;
    lat = 0;
    S_AXI_ARADDR = addr;
    S_AXI_ARLEN = 8'(len);
    S_AXI_ARVALID = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (!S_AXI_ARREADY && k < 100);
    if (!S_AXI_ARREADY) chk("ar_timeout", 0, 1);
    @(posedge clk); #1;
    S_AXI_ARVALID = 0;
    c = 0;
    while (r_done == d0 && c < 1000) begin
      S_AXI_RREADY = mode == 0 ? 1'b1 : mode == 1 ? (c % 2 == 0) : 1'($urandom_range(1));
      @(posedge clk); #1;
      c++;
      if (lat == 0 && S_AXI_RVALID) lat = c;
    end
    S_AXI_RREADY = 0;
    chk("r_timeout", r_done != d0, 1);
    chk("r_latency", lat, LAT);
    chk("r_beats", rd_cnt, len + 1);
    exp_r.delete();
    exp_l.delete();
  endtask
  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int len, lp, lastpos;
    logic [31:0] addr;
    @(posedge clk);
    pulse_reset();
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 256; i++) begin
        wbuf[i] = {$urandom, $urandom, $urandom, $urandom};
        sbuf[i] = 16'hFFFF;
      end
      wr(32'(blk * 4096), 255, 255, -1);
    end
    for (int i = 0; i < 8; i++) begin wbuf[i] = 128'(i); sbuf[i] = 16'hFFFF; end
    wr(32'h100, 7, 7, -1);
    chk("b_025", b_last, 2'b00);
    rd(32'h100, 7, 0);
    for (int i = 0; i < 8; i++) chk("r_025", rd_beats[i], 128'(i));
    for (int i = 0; i < 8; i++) begin wbuf[i] = 128'hC0DE00 + 128'(i); sbuf[i] = 16'hFFFF; end
    wr(32'h800, 7, 3, -1);
    chk("b_027", b_last, 2'b10);
    for (int i = 0; i < 8; i++) wbuf[i] = 128'hBEEF00 + 128'(i);
    wr(32'h100, 7, 7, 4);
    rd(32'h100, 7, 0);
    for (int i = 0; i < 8; i++) chk("r_030", rd_beats[i], i < 4 ? 128'hBEEF00 + 128'(i) : 128'(i));
    wbuf[0] = '1;
    sbuf[0] = 16'hFFFF;
    wr(32'h0, 0, 0, -1);
    wbuf[0] = '0;
    sbuf[0] = 16'h0001;
    wr(32'h0, 0, 0, -1);
    rd(32'h0, 0, 0);
    chk("r_026", rd_beats[0], {{120{1'b1}}, 8'h00});
    wbuf[0] = {4{32'hA5A5_1234}};
    wbuf[1] = {4{32'h5A5A_9876}};
    sbuf[0] = 16'hFFFF;
    sbuf[1] = 16'hFFFF;
    wr(32'((DEPTH - 1) * 16), 1, 1, -1);
    rd(32'((DEPTH - 1) * 16), 1, 0);
    chk("r_029_first", rd_beats[0], {4{32'hA5A5_1234}});
    chk("r_029_wrap", rd_beats[1], {4{32'h5A5A_9876}});
    rd(32'h100, 7, 1);
    chk("r_028_last", rd_beats[7], 128'(7));
    for (int t = 0; t < 20; t++) begin
      addr = $urandom;
      len = $urandom_range(15);
      lp = $urandom_range(9);
      lastpos = lp < 7 ? len : lp == 9 ? -1 : $urandom_range(len);
      for (int i = 0; i <= len; i++) begin
        wbuf[i] = {$urandom, $urandom, $urandom, $urandom};
        sbuf[i] = 16'($urandom);
      end
      wr(addr, len, lastpos, -1);
      rd(addr, len, $urandom_range(2));
      rd($urandom, $urandom_range(31), 2);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
